// File: rtl/mitchell_pkg.sv
// Shared types and default widths for the Mitchell product accumulator.
package mitchell_pkg;

  localparam int unsigned ACC_W_DEF = 36;
  localparam int unsigned LEN_W_DEF = 8;
  localparam int unsigned PROD_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/mitchell_sat_add.sv
// Combinational unsigned adder that clamps to all-ones on carry-out.
module mitchell_sat_add #(
  parameter int unsigned W = 36
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_ovf
);

  logic [W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b};
  assign o_ovf  = w_full[W];
  assign o_sum  = w_full[W] ? {W{1'b1}} : w_full[W-1:0];

endmodule

// File: rtl/mitchell_product_accumulator.sv
// Sums a frame of unsigned products with saturation and hands the total
// downstream over a valid/ready handshake.
module mitchell_product_accumulator
  import mitchell_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_prod_valid,
  input  logic [PROD_W-1:0] i_prod,
  output logic              o_prod_ready,
  output logic              o_acc_valid,
  output logic [ACC_W-1:0]  o_acc,
  output logic              o_sat,
  input  logic              i_acc_ready,
  output logic              o_busy
);

  // One extra bit so a zero length can encode a full 2^LEN_W frame.
  localparam int unsigned CNT_W = LEN_W + 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic               r_sat;
  logic               w_sat_nxt;
  logic [ACC_W-1:0]   w_sum;
  logic               w_ovf;
  logic [CNT_W-1:0]   w_len_cnt;

  mitchell_sat_add #(
    .W (ACC_W)
  ) u_sat_add (
    .i_a   (r_acc),
    .i_b   (ACC_W'(i_prod)),
    .o_sum (w_sum),
    .o_ovf (w_ovf)
  );

  assign w_len_cnt = (i_len == '0) ? {1'b1, {LEN_W{1'b0}}} : CNT_W'(i_len);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
      r_sat   <= w_sat_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    w_sat_nxt   = r_sat;
    unique case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_cnt_nxt   = w_len_cnt;
          w_acc_nxt   = '0;
          w_sat_nxt   = 1'b0;
          w_state_nxt = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (i_prod_valid) begin
          w_acc_nxt = w_sum;
          w_sat_nxt = r_sat | w_ovf;
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_acc_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_prod_ready = (r_state == ST_ACCUM);
  assign o_acc_valid  = (r_state == ST_DONE);
  assign o_busy       = (r_state != ST_IDLE);
  assign o_acc        = r_acc;
  assign o_sat        = r_sat;

endmodule

// File: tb/tb_mitchell_product_accumulator.sv
// Directed bench for the Mitchell product accumulator.
module tb_mitchell_product_accumulator;

  localparam int unsigned ACC_W = 36;
  localparam int unsigned LEN_W = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             prod_valid;
  logic [31:0]      prod;
  logic             prod_ready;
  logic             acc_valid;
  logic [ACC_W-1:0] acc;
  logic             sat;
  logic             acc_ready;
  logic             busy;

  int checks = 0;
  int errors = 0;
  logic [ACC_W-1:0] held;

  mitchell_product_accumulator #(
    .ACC_W (ACC_W),
    .LEN_W (LEN_W)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_len        (len),
    .i_prod_valid (prod_valid),
    .i_prod       (prod),
    .o_prod_ready (prod_ready),
    .o_acc_valid  (acc_valid),
    .o_acc        (acc),
    .o_sat        (sat),
    .i_acc_ready  (acc_ready),
    .o_busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; prod_valid = 1'b0; prod = '0; acc_ready = 1'b0;
    tick(); tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_acc", 64'(acc), 64'd0);
    chk("rst_sat", 64'(sat), 64'd0);
    chk("rst_valid", 64'(acc_valid), 64'd0);
    chk("rst_ready", 64'(prod_ready), 64'd0);
    rst = 1'b0;

    // Frame of three back-to-back beats.
    tick();
    start = 1'b1; len = 8'd3;
    tick();
    start = 1'b0;
    chk("f1_ready", 64'(prod_ready), 64'd1);
    chk("f1_busy", 64'(busy), 64'd1);
    prod_valid = 1'b1; prod = 32'd10;
    tick(); prod = 32'd20;
    tick(); prod = 32'd30;
    chk("f1_valid_early", 64'(acc_valid), 64'd0);
    tick();
    prod_valid = 1'b0;
    chk("f1_valid", 64'(acc_valid), 64'd1);
    chk("f1_acc", 64'(acc), 64'd60);
    chk("f1_sat", 64'(sat), 64'd0);
    chk("f1_ready_done", 64'(prod_ready), 64'd0);
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    chk("f1_valid_drop", 64'(acc_valid), 64'd0);
    chk("f1_idle", 64'(busy), 64'd0);

    // Bubbly upstream: valid toggles, garbage on idle beats.
    start = 1'b1; len = 8'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("f2_ready", 64'(prod_ready), 64'd1);
      prod_valid = (i % 2 == 0);
      prod = (i % 2 == 0) ? 32'(i / 2 + 1) : 32'd99;
      tick();
    end
    prod_valid = 1'b0;
    chk("f2_valid", 64'(acc_valid), 64'd1);
    chk("f2_acc", 64'(acc), 64'd10);
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;

    // Saturation: 17 beats of all-ones overflow a 36-bit accumulator.
    start = 1'b1; len = 8'd17;
    tick();
    start = 1'b0;
    prod_valid = 1'b1; prod = 32'hFFFF_FFFF;
    for (int i = 0; i < 16; i++) tick();
    chk("f3_acc16", 64'(acc), 64'hF_FFFF_FFF0);
    chk("f3_sat16", 64'(sat), 64'd0);
    tick();
    prod_valid = 1'b0;
    chk("f3_acc", 64'(acc), 64'hF_FFFF_FFFF);
    chk("f3_sat", 64'(sat), 64'd1);
    held = 36'hF_FFFF_FFFF;

    // Stall downstream for 5 cycles with start pulsing; then handoff with start.
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      tick();
      chk("f3_hold_acc", 64'(acc), 64'(held));
      chk("f3_hold_valid", 64'(acc_valid), 64'd1);
    end
    acc_ready = 1'b1; start = 1'b1; len = 8'd2;
    tick();
    acc_ready = 1'b0; start = 1'b0;
    chk("f3_handoff_busy", 64'(busy), 64'd0);
    chk("f3_handoff_ready", 64'(prod_ready), 64'd0);

    // Mid-frame reset abandons the frame.
    start = 1'b1; len = 8'd5;
    tick();
    start = 1'b0;
    prod_valid = 1'b1; prod = 32'd3;
    tick(); prod = 32'd4;
    tick();
    prod_valid = 1'b0;
    chk("f4_partial", 64'(acc), 64'd7);
    #2 rst = 1'b1;
    #1;
    chk("f4_rst_busy", 64'(busy), 64'd0);
    chk("f4_rst_acc", 64'(acc), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("f4_no_emit", 64'(acc_valid), 64'd0);
    start = 1'b1; len = 8'd1;
    tick();
    start = 1'b0;
    prod_valid = 1'b1; prod = 32'd7;
    tick();
    prod_valid = 1'b0;
    chk("f4_valid", 64'(acc_valid), 64'd1);
    chk("f4_acc", 64'(acc), 64'd7);
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;

    // Zero length means a full 256-beat frame.
    start = 1'b1; len = 8'd0;
    tick();
    start = 1'b0;
    prod_valid = 1'b1; prod = 32'd1;
    for (int i = 0; i < 256; i++) begin
      if (i == 0 || i == 255) begin
        chk("f5_ready", 64'(prod_ready), 64'd1);
        chk("f5_valid_early", 64'(acc_valid), 64'd0);
      end
      tick();
    end
    chk("f5_valid", 64'(acc_valid), 64'd1);
    chk("f5_acc", 64'(acc), 64'd256);
    chk("f5_ready_done", 64'(prod_ready), 64'd0);
    tick();
    prod_valid = 1'b0;
    chk("f5_acc_held", 64'(acc), 64'd256);
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    chk("f5_idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
